lamp_monitor: RTL and testbench

- Observer at the lamp end of the car-lamp interface. Watches the two 3-bit turn/brake lamp buses and the two seven-segment digit buses, and decodes them back into a car state code and two BCD digits.
- Flags illegal sweep sequences, stalled sweeps and undecodable segment patterns.
- Sits beside water_lamp in the simulation and FPGA build as a self-check and status block.

---
 rtl/lamp_pkg.sv | 42 ++++
 rtl/lamp_monitor_tracker.sv | 76 +++++++
 rtl/lamp_monitor.sv | 93 +++++++++
 tb/tb_lamp_monitor.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/lamp_pkg.sv
// lamp_pkg: shared constants, tracker state encoding and seven-segment decode for lamp_monitor.
package lamp_pkg;
  typedef enum logic [1:0] {ST_OFF, ST_SWEEP, ST_PEND, ST_STEADY} trk_state_t;
  localparam logic [2:0] MODE_IDLE        = 3'd0;
  localparam logic [2:0] MODE_LEFT        = 3'd1;
  localparam logic [2:0] MODE_RIGHT       = 3'd2;
  localparam logic [2:0] MODE_HAZARD      = 3'd3;
  localparam logic [2:0] MODE_BRAKE       = 3'd4;
  localparam logic [2:0] MODE_LEFT_BRAKE  = 3'd5;
  localparam logic [2:0] MODE_RIGHT_BRAKE = 3'd6;
  localparam logic [2:0] MODE_INVALID     = 3'd7;
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_P0  = 3'b001;
  localparam logic [2:0] LAMP_P1  = 3'b010;
  localparam logic [2:0] LAMP_P2  = 3'b100;
  localparam logic [2:0] LAMP_ALL = 3'b111;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    case (s)
      SEG_0: return 4'd0;
      SEG_1: return 4'd1;
      SEG_2: return 4'd2;
      SEG_3: return 4'd3;
      SEG_4: return 4'd4;
      SEG_5: return 4'd5;
      SEG_6: return 4'd6;
      SEG_7: return 4'd7;
      SEG_8: return 4'd8;
      SEG_9: return 4'd9;
      default: return 4'hF;
    endcase
  endfunction
endpackage

// File: rtl/lamp_monitor_tracker.sv
// lamp_side_tracker: per-side sweep/brake FSM with stall timer, hold timer and sweep counter.
// Sweep counter exists only when LAMP_MON_COUNT_EN is defined.
module lamp_side_tracker
  import lamp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int HOLD_CYC    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cur,
  input  logic [2:0]       prev,
  output trk_state_t       state,
  output logic             err,
  output logic [CNT_W-1:0] cnt
);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  trk_state_t state_d, state_q;
  logic [IW-1:0] idle_d, idle_q;
  logic [HW-1:0] hold_d, hold_q;
  logic err_d, err_q, step, legal;
  always_comb begin
    step  = (prev == LAMP_P0 && cur == LAMP_P1) || (prev == LAMP_P1 && cur == LAMP_P2) ||
            (prev == LAMP_P2 && cur == LAMP_P0);
    legal = cur == LAMP_OFF || (prev == LAMP_OFF && (cur == LAMP_P0 || cur == LAMP_ALL)) || step;
    state_d = state_q;
    idle_d  = idle_q;
    hold_d  = hold_q;
    err_d   = 1'b0;
    if (cur != prev) begin
      idle_d = '0;
      hold_d = '0;
      if (!legal) begin
        state_d = ST_OFF;
        err_d   = 1'b1;
      end else if (cur == LAMP_OFF) state_d = ST_OFF;
      else if (cur == LAMP_ALL) state_d = ST_PEND;
      else if (cur == LAMP_P0) state_d = ST_SWEEP;
    end else if (state_q == ST_SWEEP) begin
      if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
        state_d = ST_OFF;
        err_d   = 1'b1;
      end else idle_d = idle_q + 1'b1;
    end else if (state_q == ST_PEND) begin
      if (hold_q == HW'(HOLD_CYC - 1)) state_d = ST_STEADY;
      else hold_d = hold_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      idle_q  <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end
  assign state = state_q;
  assign err   = err_q;
`ifdef LAMP_MON_COUNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb
    cnt_d = (state_q == ST_SWEEP && prev == LAMP_P2 && cur == LAMP_P0 && cnt_q != '1) ?
            cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif
endmodule

// File: rtl/lamp_monitor.sv
// lamp_monitor: decodes lamp and digit buses back into car mode and BCD digits, flagging bad sequences.
// Optional sweep counters enabled by LAMP_MON_COUNT_EN.
module lamp_monitor
  import lamp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int HOLD_CYC    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ledL,
  input  logic [2:0]       ledR,
  input  logic [6:0]       ledNum1,
  input  logic [6:0]       ledNum2,
  output logic [2:0]       mode,
  output logic             mode_valid,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic             seg_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] sweepL_cnt,
  output logic [CNT_W-1:0] sweepR_cnt
);
  logic [2:0] led_l_q, led_r_q, led_l_p_q, led_r_p_q;
  logic [6:0] num1_q, num2_q, num1_p_q, num2_p_q;
  trk_state_t st_l, st_r;
  logic err_l, err_r;
  logic [CNT_W-1:0] cnt_l, cnt_r, cnt_l_q, cnt_r_q;
  logic [2:0] mode_d, mode_q;
  logic [3:0] digit1_d, digit1_q, digit2_d, digit2_q;
  logic mode_valid_d, mode_valid_q, seg_err_d, seg_err_q, seq_err_d, seq_err_q;
  lamp_side_tracker #(.TIMEOUT_CYC(TIMEOUT_CYC), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) u_left (
    .clk(clk), .rst(rst), .cur(led_l_q), .prev(led_l_p_q), .state(st_l), .err(err_l), .cnt(cnt_l)
  );
  lamp_side_tracker #(.TIMEOUT_CYC(TIMEOUT_CYC), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) u_right (
    .clk(clk), .rst(rst), .cur(led_r_q), .prev(led_r_p_q), .state(st_r), .err(err_r), .cnt(cnt_r)
  );
  // Tracker state lines up with the stage-2 patterns, so hazard phase compares those.
  always_comb begin
    digit1_d  = seg_decode(num1_p_q);
    digit2_d  = seg_decode(num2_p_q);
    seg_err_d = digit1_d == 4'hF || digit2_d == 4'hF;
    seq_err_d = err_l | err_r;
    mode_d = (st_l == ST_OFF    && st_r == ST_OFF)    ? MODE_IDLE :
             (st_l == ST_SWEEP  && st_r == ST_OFF)    ? MODE_LEFT :
             (st_l == ST_OFF    && st_r == ST_SWEEP)  ? MODE_RIGHT :
             (st_l == ST_SWEEP  && st_r == ST_SWEEP && led_l_p_q == led_r_p_q) ? MODE_HAZARD :
             (st_l == ST_STEADY && st_r == ST_STEADY) ? MODE_BRAKE :
             (st_l == ST_SWEEP  && st_r == ST_STEADY) ? MODE_LEFT_BRAKE :
             (st_l == ST_STEADY && st_r == ST_SWEEP)  ? MODE_RIGHT_BRAKE : MODE_INVALID;
    mode_valid_d = mode_d != MODE_INVALID && !seq_err_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {led_l_q, led_r_q, led_l_p_q, led_r_p_q} <= '0;
      {num1_q, num2_q, num1_p_q, num2_p_q}     <= '0;
      mode_q       <= MODE_IDLE;
      mode_valid_q <= 1'b0;
      digit1_q     <= 4'hF;
      digit2_q     <= 4'hF;
      seg_err_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      cnt_l_q      <= '0;
      cnt_r_q      <= '0;
    end else begin
      led_l_q      <= ledL;
      led_r_q      <= ledR;
      num1_q       <= ledNum1;
      num2_q       <= ledNum2;
      led_l_p_q    <= led_l_q;
      led_r_p_q    <= led_r_q;
      num1_p_q     <= num1_q;
      num2_p_q     <= num2_q;
      mode_q       <= mode_d;
      mode_valid_q <= mode_valid_d;
      digit1_q     <= digit1_d;
      digit2_q     <= digit2_d;
      seg_err_q    <= seg_err_d;
      seq_err_q    <= seq_err_d;
      cnt_l_q      <= cnt_l;
      cnt_r_q      <= cnt_r;
    end
  end
  assign mode       = mode_q;
  assign mode_valid = mode_valid_q;
  assign digit1     = digit1_q;
  assign digit2     = digit2_q;
  assign seg_err    = seg_err_q;
  assign seq_err    = seq_err_q;
  assign sweepL_cnt = cnt_l_q;
  assign sweepR_cnt = cnt_r_q;
endmodule

// File: tb/tb_lamp_monitor.sv
// tb_lamp_monitor: directed self-checking bench for lamp_monitor.
module tb_lamp_monitor;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] ledL, ledR;
  logic [6:0] ledNum1, ledNum2;
  logic [2:0] mode;
  logic mode_valid, seg_err, seq_err;
  logic [3:0] digit1, digit2;
  logic [7:0] sweepL_cnt, sweepR_cnt;
  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int err_mark;
`ifdef LAMP_MON_COUNT_EN
  localparam logic [7:0] CNT_ONE = 8'd1;
`else
  localparam logic [7:0] CNT_ONE = 8'd0;
`endif
  always #5 clk = ~clk;
  lamp_monitor dut (
    .clk(clk), .rst(rst), .ledL(ledL), .ledR(ledR), .ledNum1(ledNum1), .ledNum2(ledNum2),
    .mode(mode), .mode_valid(mode_valid), .digit1(digit1), .digit2(digit2),
    .seg_err(seg_err), .seq_err(seq_err), .sweepL_cnt(sweepL_cnt), .sweepR_cnt(sweepR_cnt)
  );
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (seq_err === 1'b1) err_cnt++;
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1'b1; ledL = 3'b000; ledR = 3'b000; ledNum1 = 7'h3F; ledNum2 = 7'h06;
    run(2);
    chk("rst_mode", 8'(mode), 8'd0);
    chk("rst_valid", 8'(mode_valid), 8'd0);
    chk("rst_d1", 8'(digit1), 8'hF);
    chk("rst_d2", 8'(digit2), 8'hF);
    chk("rst_segerr", 8'(seg_err), 8'd0);
    chk("rst_seqerr", 8'(seq_err), 8'd0);
    chk("rst_cntL", sweepL_cnt, 8'd0);
    rst = 1'b0;
    run(3);
    chk("idle_mode", 8'(mode), 8'd0);
    chk("idle_valid", 8'(mode_valid), 8'd1);
    chk("idle_d1", 8'(digit1), 8'd0);
    chk("idle_d2", 8'(digit2), 8'd1);
    // left sweep, one full cycle
    err_mark = err_cnt;
    ledL = 3'b001; run(10);
    ledL = 3'b010; run(10);
    ledL = 3'b100; run(10);
    ledL = 3'b001; run(10);
    chk("left_mode", 8'(mode), 8'd1);
    chk("left_valid", 8'(mode_valid), 8'd1);
    chk("left_cnt", sweepL_cnt, CNT_ONE);
    chk("left_cntR", sweepR_cnt, 8'd0);
    chk("left_noerr", 8'(err_cnt - err_mark), 8'd0);
    ledL = 3'b000; run(3);
    chk("left_off", 8'(mode), 8'd0);
    // brake: PEND window then STEADY
    ledL = 3'b111; ledR = 3'b111; run(3);
    chk("pend_a", 8'(mode), 8'd7);
    chk("pend_a_valid", 8'(mode_valid), 8'd0);
    run(3);
    chk("pend_b", 8'(mode), 8'd7);
    run(1);
    chk("brake", 8'(mode), 8'd4);
    chk("brake_valid", 8'(mode_valid), 8'd1);
    run(4);
    ledL = 3'b000; ledR = 3'b000; run(3);
    chk("brake_off", 8'(mode), 8'd0);
    chk("brake_noerr", 8'(err_cnt - err_mark), 8'd0);
    // illegal right step
    ledR = 3'b001; run(3);
    chk("right_mode", 8'(mode), 8'd2);
    err_mark = err_cnt;
    ledR = 3'b100; run(2);
    chk("ill_pre", 8'(seq_err), 8'd0);
    run(1);
    chk("ill_pulse", 8'(seq_err), 8'd1);
    chk("ill_valid", 8'(mode_valid), 8'd0);
    chk("ill_mode", 8'(mode), 8'd0);
    run(1);
    chk("ill_post", 8'(seq_err), 8'd0);
    chk("ill_post_valid", 8'(mode_valid), 8'd1);
    ledR = 3'b001; run(3);
    chk("restart_mode", 8'(mode), 8'd2);
    ledL = 3'b111; run(3);
    chk("rb_pend", 8'(mode), 8'd7);
    run(4);
    chk("rb_mode", 8'(mode), 8'd6);
    chk("ill_once", 8'(err_cnt - err_mark), 8'd1);
    ledL = 3'b000; ledR = 3'b000; run(3);
    chk("rb_off", 8'(mode), 8'd0);
    // stall in SWEEP
    ledL = 3'b001; run(5);
    err_mark = err_cnt;
    ledL = 3'b010; run(66);
    chk("stall_pre", 8'(seq_err), 8'd0);
    chk("stall_pre_mode", 8'(mode), 8'd1);
    run(1);
    chk("stall_pulse", 8'(seq_err), 8'd1);
    chk("stall_mode", 8'(mode), 8'd0);
    run(1);
    chk("stall_post", 8'(seq_err), 8'd0);
    run(5);
    chk("stall_once", 8'(err_cnt - err_mark), 8'd1);
    chk("stall_valid", 8'(mode_valid), 8'd1);
    ledL = 3'b000; run(3);
    // segment decode
    ledNum1 = 7'h5B; ledNum2 = 7'h6F; run(3);
    chk("seg_d1", 8'(digit1), 8'd2);
    chk("seg_d2", 8'(digit2), 8'd9);
    chk("seg_ok", 8'(seg_err), 8'd0);
    ledNum2 = 7'h01; run(3);
    chk("seg_bad_d2", 8'(digit2), 8'hF);
    chk("seg_bad_d1", 8'(digit1), 8'd2);
    chk("seg_bad", 8'(seg_err), 8'd1);
    ledNum2 = 7'h6F; run(3);
    chk("seg_rec", 8'(seg_err), 8'd0);
    // hazard, reset mid-sweep, resume
    ledL = 3'b001; ledR = 3'b001; run(3);
    chk("haz_mode", 8'(mode), 8'd3);
    ledL = 3'b010; ledR = 3'b010; run(5);
    chk("haz_mode2", 8'(mode), 8'd3);
    rst = 1'b1; run(1);
    chk("mrst_mode", 8'(mode), 8'd0);
    chk("mrst_valid", 8'(mode_valid), 8'd0);
    chk("mrst_d1", 8'(digit1), 8'hF);
    chk("mrst_seq", 8'(seq_err), 8'd0);
    chk("mrst_seg", 8'(seg_err), 8'd0);
    rst = 1'b0;
    err_mark = err_cnt;
    run(5);
    chk("mrst_err_single", 8'(err_cnt - err_mark), 8'd1);
    chk("mrst_off", 8'(mode), 8'd0);
    ledL = 3'b100; ledR = 3'b100; run(5);
    chk("mrst_still_off", 8'(mode), 8'd0);
    ledL = 3'b001; ledR = 3'b001; run(3);
    chk("resume_haz", 8'(mode), 8'd3);
    chk("resume_valid", 8'(mode_valid), 8'd1);
    chk("resume_cnt", sweepL_cnt, 8'd0);
    ledL = 3'b010; run(3);
    chk("out_of_phase", 8'(mode), 8'd7);
    chk("resume_errs", 8'(err_cnt - err_mark), 8'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
